// File: rtl/l2_port_arbiter.sv
// Two-port arbiter for the L2 port, shared by JTAG (port 0) and a system master (port 1).
// Round-robin with burst lock. Defining L2_ARB_JTAG_PRIO_EN makes port 0 win every tie.
module l2_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2,
  parameter int MAX_LOCK  = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               req_i,
  input  logic [1:0]               lock_i,
  input  logic [1:0][ADDR_W-1:0]   addr_i,
  input  logic [1:0]               we_i,
  input  logic [1:0][DATA_W/8-1:0] be_i,
  input  logic [1:0][DATA_W-1:0]   wdata_i,
  output logic [1:0]               gnt_o,
  output logic [1:0]               rvalid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic                     mem_we_o,
  output logic [DATA_W/8-1:0]      mem_be_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  output logic                     lock_break_o
);

  localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTST + 1);
  localparam int LCNT_W = $clog2(MAX_LOCK + 1);
  localparam int LB_W   = LCNT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t               state_reg;
  logic                 last_reg;
  logic                 hold_valid_reg;
  logic                 hold_port_reg;
  logic [LCNT_W-1:0]    lock_cnt_reg;
  logic [MAX_OUTST-1:0] id_mem_reg;
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;

  logic            win;
  logic            win_req;
  logic            fifo_full;
  logic            accept;
  logic            pop;
  logic            head;
  logic [LB_W-1:0] lock_beats;
  logic            break_hit;

  // A waiting winner keeps the port until it is served or withdraws its request.
  always_comb begin
    win = 1'b0;
    case (state_reg)
      LOCK0: win = 1'b0;
      LOCK1: win = 1'b1;
      default: begin
        if (hold_valid_reg && req_i[hold_port_reg]) begin
          win = hold_port_reg;
        end else if (&req_i) begin
`ifdef L2_ARB_JTAG_PRIO_EN
          win = 1'b0;
`else
          win = ~last_reg;
`endif
        end else begin
          win = req_i[1];
        end
      end
    endcase
  end

  assign fifo_full   = (count_reg == CNT_W'(MAX_OUTST));
  assign win_req     = req_i[win];
  assign mem_req_o   = win_req & ~fifo_full & ~rst_i;
  assign accept      = mem_req_o & mem_gnt_i;
  assign mem_addr_o  = addr_i[win];
  assign mem_we_o    = we_i[win];
  assign mem_be_o    = be_i[win];
  assign mem_wdata_o = wdata_i[win];

  assign head    = id_mem_reg[rd_ptr_reg];
  assign pop     = mem_rvalid_i & (count_reg != '0) & ~rst_i;
  assign rdata_o = mem_rdata_i;

  // Beats of the current burst including this one; a fresh burst starts at 1.
  assign lock_beats   = (state_reg == IDLE) ? LB_W'(1) : ({1'b0, lock_cnt_reg} + LB_W'(1));
  assign break_hit    = accept & lock_i[win] & (lock_beats >= LB_W'(MAX_LOCK));
  assign lock_break_o = break_hit;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign gnt_o[gi]    = accept & (win == 1'(gi));
      assign rvalid_o[gi] = pop & (head == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      last_reg       <= 1'b1;
      hold_valid_reg <= 1'b0;
      hold_port_reg  <= 1'b0;
      lock_cnt_reg   <= '0;
      id_mem_reg     <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      hold_valid_reg <= win_req & ~accept;
      hold_port_reg  <= win;
      if (accept) begin
        last_reg               <= win;
        id_mem_reg[wr_ptr_reg] <= win;
        wr_ptr_reg             <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(accept) - CNT_W'(pop);

      case (state_reg)
        IDLE: begin
          if (accept && lock_i[win] && !break_hit) begin
            state_reg    <= win ? LOCK1 : LOCK0;
            lock_cnt_reg <= LCNT_W'(1);
          end
        end
        default: begin
          if (accept) begin
            if (!lock_i[win] || break_hit) begin
              state_reg    <= IDLE;
              lock_cnt_reg <= '0;
            end else begin
              lock_cnt_reg <= lock_beats[LCNT_W-1:0];
            end
          end else if (!req_i[win] && !lock_i[win]) begin
            state_reg    <= IDLE;
            lock_cnt_reg <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Randomized and directed bench for l2_port_arbiter against a queue-based reference model.
// Honours L2_ARB_JTAG_PRIO_EN when computing tie-break expectations.
module tb_l2_port_arbiter;

  localparam int MAX_OUTST = 2;
  localparam int MAX_LOCK  = 4;
`ifdef L2_ARB_JTAG_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       req, lock, we;
  logic [1:0][31:0] addr, wdata;
  logic [1:0][3:0]  be;
  logic             mem_gnt, mem_rvalid;
  logic [31:0]      mem_rdata;
  logic [1:0]       gnt_o, rvalid_o;
  logic [31:0]      rdata_o, mem_addr_o, mem_wdata_o;
  logic             mem_req_o, mem_we_o, lock_break_o;
  logic [3:0]       mem_be_o;

  l2_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUTST(MAX_OUTST), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .lock_break_o(lock_break_o)
  );

  typedef struct {
    int        port;
    bit        rd;
    bit [31:0] data;
  } resp_t;

  resp_t     m_q[$];      // expected responses in issue order
  bit [31:0] l2_q[$];     // L2 model response pipeline
  bit [31:0] ref_mem[8];
  bit [31:0] l2_mem[8];
  int        m_owner, m_last, m_pend, m_beats;
  int        checks, errors, rv_mode;
  logic [1:0]  obs_gnt, obs_rvalid, hold;
  logic        obs_req, obs_break;
  logic [31:0] obs_rdata, obs_wdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] merge(bit [31:0] old_v, bit [31:0] new_v, bit [3:0] be_v);
    for (int i = 0; i < 4; i++) if (be_v[i]) old_v[8*i +: 8] = new_v[8*i +: 8];
    return old_v;
  endfunction

  // One clock: drive L2 response, check DUT against model, advance model and L2.
  task automatic step();
    int w, beats, ridx, lidx;
    bit exp_req, acc, pop, brk;
    logic [1:0] exp_gnt, exp_rv;
    resp_t r;
    case (rv_mode)
      1:       mem_rvalid = 1'b0;
      2:       mem_rvalid = (l2_q.size() > 0);
      default: mem_rvalid = (l2_q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
    endcase
    mem_rdata = (l2_q.size() > 0) ? l2_q[0] : $urandom;
    #1;
    if (m_owner >= 0) w = m_owner;
    else if (m_pend >= 0 && req[m_pend]) w = m_pend;
    else if (req == 2'b11) w = PRIO ? 0 : 1 - m_last;
    else w = req[1] ? 1 : 0;
    exp_req = !rst && req[w] && (m_q.size() < MAX_OUTST);
    acc     = exp_req && mem_gnt;
    exp_gnt = acc ? 2'(1 << w) : 2'b00;
    beats   = (m_owner >= 0) ? m_beats + 1 : 1;
    brk     = acc && lock[w] && (beats >= MAX_LOCK);
    pop     = !rst && mem_rvalid && (m_q.size() > 0);
    exp_rv  = pop ? 2'(1 << m_q[0].port) : 2'b00;

    check_eq("gnt", 32'(gnt_o), 32'(exp_gnt));
    check_eq("mem_req", 32'(mem_req_o), 32'(exp_req));
    check_eq("rvalid", 32'(rvalid_o), 32'(exp_rv));
    check_eq("lock_break", 32'(lock_break_o), 32'(brk));
    if (exp_req) begin
      check_eq("mem_addr", mem_addr_o, addr[w]);
      check_eq("mem_we", 32'(mem_we_o), 32'(we[w]));
      check_eq("mem_be", 32'(mem_be_o), 32'(be[w]));
      if (we[w]) check_eq("mem_wdata", mem_wdata_o, wdata[w]);
    end
    if (pop && m_q[0].rd) check_eq("rdata", rdata_o, m_q[0].data);

    obs_gnt = gnt_o; obs_rvalid = rvalid_o; obs_req = mem_req_o;
    obs_break = lock_break_o; obs_rdata = rdata_o; obs_wdata = mem_wdata_o;

    if (mem_rvalid && l2_q.size() > 0) l2_q.delete(0);
    if (mem_req_o && mem_gnt) begin
      lidx = int'(mem_addr_o[4:2]);
      l2_q.push_back(l2_mem[lidx]);
      if (mem_we_o) l2_mem[lidx] = merge(l2_mem[lidx], mem_wdata_o, mem_be_o);
    end

    if (rst) begin
      m_owner = -1; m_last = 1; m_pend = -1; m_beats = 0;
      m_q.delete();
    end else begin
      if (pop) m_q.delete(0);
      if (acc) begin
        ridx   = int'(addr[w][4:2]);
        r.port = w; r.rd = !we[w]; r.data = ref_mem[ridx];
        m_q.push_back(r);
        if (we[w]) ref_mem[ridx] = merge(ref_mem[ridx], wdata[w], be[w]);
        m_last = w;
        $display("beat t=%0t port=%0d we=%0b addr=%08h lock=%0b", $time, w, we[w], addr[w], lock[w]);
        if (m_owner < 0) begin
          if (lock[w] && !brk) begin m_owner = w; m_beats = 1; end
        end else if (!lock[w] || brk) begin
          m_owner = -1;
        end else begin
          m_beats = beats;
        end
      end else if (m_owner >= 0 && !req[w] && !lock[w]) begin
        m_owner = -1;
      end
      m_pend = (req[w] && !acc) ? w : -1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; lock = 2'b00;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic drain();
    req = 2'b00; lock = 2'b00; rv_mode = 2;
    for (int i = 0; i < 20 && (l2_q.size() > 0 || m_q.size() > 0); i++) step();
    check_eq("drain", 32'(l2_q.size()), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; rv_mode = 1;
    m_owner = -1; m_last = 1; m_pend = -1; m_beats = 0; hold = 2'b00;
    for (int i = 0; i < 8; i++) begin ref_mem[i] = '0; l2_mem[i] = '0; end
    rst = 1'b1; req = 2'b11; lock = 2'b00; we = 2'b00; mem_gnt = 1'b1;
    addr = '0; wdata = '0; be = {4'hF, 4'hF}; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);

    // Outputs held low while reset is asserted, even with requests and gnt high
    step();
    check_eq("rst_gnt", 32'(obs_gnt), 32'd0);
    check_eq("rst_req", 32'(obs_req), 32'd0);
    check_eq("rst_break", 32'(obs_break), 32'd0);
    do_reset();

    // Single write then read back
    rv_mode = 2; mem_gnt = 1'b1;
    we[0] = 1'b1; addr[0] = 32'h0; wdata[0] = 32'hABBAABBA; be[0] = 4'hF; req = 2'b01;
    step();
    check_eq("sw_gnt", 32'(obs_gnt), 32'h1);
    check_eq("sw_wdata", obs_wdata, 32'hABBAABBA);
    req = 2'b00; step();
    check_eq("sw_rvalid", 32'(obs_rvalid), 32'h1);
    we[0] = 1'b0; req = 2'b01; step();
    check_eq("rd_gnt", 32'(obs_gnt), 32'h1);
    req = 2'b00; step();
    check_eq("rd_rvalid", 32'(obs_rvalid), 32'h1);
    check_eq("rd_data", obs_rdata, 32'hABBAABBA);
    drain();

    // Round-robin with both ports requesting
    do_reset(); rv_mode = 2; we = 2'b00; addr[1] = 32'h4; req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("rr_grant", 32'(obs_gnt), (PRIO || (i % 2 == 0)) ? 32'h1 : 32'h2);
    end
    drain();

    // Burst lock: port 0 holds lock for three beats, releases on the fourth
    do_reset(); rv_mode = 2;
    for (int i = 0; i < 5; i++) begin
      req = 2'b11; lock = (i < 3) ? 2'b01 : 2'b00;
      step();
      check_eq("lock_grant", 32'(obs_gnt), (i < 4 || PRIO) ? 32'h1 : 32'h2);
    end
    drain();

    // Lock break at MAX_LOCK beats
    do_reset(); rv_mode = 2;
    for (int i = 0; i < 6; i++) begin
      req = 2'b11; lock = 2'b01;
      step();
      check_eq("brk_flag", 32'(obs_break), (i == 3) ? 32'h1 : 32'h0);
      if (i < 5) check_eq("brk_grant", 32'(obs_gnt), (i < 4 || PRIO) ? 32'h1 : 32'h2);
    end
    drain();

    // FIFO full backpressure and in-order response routing
    do_reset(); rv_mode = 1; req = 2'b11;
    step(); check_eq("ff_gnt1", 32'(obs_gnt), 32'h1);
    step(); check_eq("ff_gnt2", 32'(obs_gnt), PRIO ? 32'h1 : 32'h2);
    req = 2'b01;
    step(); check_eq("ff_req", 32'(obs_req), 32'h0);
    check_eq("ff_gnt3", 32'(obs_gnt), 32'h0);
    rv_mode = 2;
    step(); check_eq("ff_rv1", 32'(obs_rvalid), 32'h1);
    check_eq("ff_req2", 32'(obs_req), 32'h0);
    step(); check_eq("ff_rv2", 32'(obs_rvalid), PRIO ? 32'h1 : 32'h2);
    check_eq("ff_gnt4", 32'(obs_gnt), 32'h1);
    drain();

    // Reset in the middle of a locked port 1 burst with two outstanding
    do_reset(); rv_mode = 1; req = 2'b10; lock = 2'b10;
    step(); check_eq("mb_gnt1", 32'(obs_gnt), 32'h2);
    step(); check_eq("mb_gnt2", 32'(obs_gnt), 32'h2);
    rst = 1'b1;
    step();
    check_eq("mb_req", 32'(obs_req), 32'h0);
    check_eq("mb_gnt", 32'(obs_gnt), 32'h0);
    check_eq("mb_rvalid", 32'(obs_rvalid), 32'h0);
    rst = 1'b0; req = 2'b00; lock = 2'b10; rv_mode = 2;
    step(); check_eq("mb_late1", 32'(obs_rvalid), 32'h0);
    step(); check_eq("mb_late2", 32'(obs_rvalid), 32'h0);
    req = 2'b01;
    step(); check_eq("mb_unlock", 32'(obs_gnt), 32'h1);
    drain();

    // Randomized traffic with random L2 grant and response timing
    do_reset(); rv_mode = 0; hold = 2'b00;
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!hold[p]) begin
          req[p]   = ($urandom_range(0, 9) < 6);
          we[p]    = 1'($urandom_range(0, 1));
          addr[p]  = 32'($urandom_range(0, 7)) << 2;
          wdata[p] = $urandom;
          be[p]    = 4'($urandom_range(1, 15));
          lock[p]  = lock[p] ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 5) == 0);
        end
      end
      mem_gnt = ($urandom_range(0, 3) != 0);
      step();
      hold = req & ~obs_gnt;
    end
    mem_gnt = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
